alu_rr_sched: RTL and testbench

- Round-robin scheduler plus sequencer that shares one iterative ALU datapath between two requesters.
- Arbitrates requests, latches operands, and runs the operation:
  - ADD/SUB in a single cycle.
  - MUL by shift-add over WIDTH cycles.
  - DIV by restoring division over WIDTH cycles.
- Returns the result with a done pulse tagged by requester ID.
- Sits between two client blocks and the arithmetic datapath, replacing per-client combinational ALUs.

---
 rtl/alu_rr_sched_if.sv | 44 ++++
 rtl/alu_rr_sched.sv | 177 +++++++++++++++++
 tb/tb_alu_rr_sched.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_rr_sched_if.sv
// Request/grant/result bundle between two clients (master) and the shared ALU sequencer (slave).
// Counter signals are present only when ALU_STATS_EN is defined.
interface alu_rr_sched_if #(
   parameter int unsigned WIDTH = 8
);
   logic               req0;
   logic [WIDTH-1:0]   a0;
   logic [WIDTH-1:0]   b0;
   logic [2:0]         sel0;
   logic               req1;
   logic [WIDTH-1:0]   a1;
   logic [WIDTH-1:0]   b1;
   logic [2:0]         sel1;
   logic               gnt0;
   logic               gnt1;
   logic               busy;
   logic               done;
   logic               done_id;
   logic [2*WIDTH-1:0] y;
   logic               err;
`ifdef ALU_STATS_EN
   logic [15:0]        ops_cnt0;
   logic [15:0]        ops_cnt1;
   logic [15:0]        err_cnt;

   modport master (
      output req0, a0, b0, sel0, req1, a1, b1, sel1,
      input  gnt0, gnt1, busy, done, done_id, y, err, ops_cnt0, ops_cnt1, err_cnt
   );
   modport slave (
      input  req0, a0, b0, sel0, req1, a1, b1, sel1,
      output gnt0, gnt1, busy, done, done_id, y, err, ops_cnt0, ops_cnt1, err_cnt
   );
`else
   modport master (
      output req0, a0, b0, sel0, req1, a1, b1, sel1,
      input  gnt0, gnt1, busy, done, done_id, y, err
   );
   modport slave (
      input  req0, a0, b0, sel0, req1, a1, b1, sel1,
      output gnt0, gnt1, busy, done, done_id, y, err
   );
`endif
endinterface

// File: rtl/alu_rr_sched.sv
// Two-client round-robin scheduler sharing one iterative ALU (ADD/SUB 1 cycle, MUL/DIV WIDTH cycles).
// Optional per-client op counters and error counter under ALU_STATS_EN.
module alu_rr_sched #(
   parameter int unsigned WIDTH = 8
) (
   input logic           clk,
   input logic           rst,
   alu_rr_sched_if.slave bus
);
   localparam int unsigned RW = 2 * WIDTH;
   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [2:0]  OP_ADD = 3'b000;
   localparam logic [2:0]  OP_SUB = 3'b001;
   localparam logic [2:0]  OP_MUL = 3'b010;
   localparam logic [2:0]  OP_DIV = 3'b011;

   typedef enum logic [1:0] {IDLE, EXEC, MUL, DIV} state_t;

   state_t           state_q;
   logic             last_q;
   logic [CW-1:0]    cnt_q;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q, sh_q, rem_q;
   logic [RW-1:0]    mcand_q, prod_q;
   logic             divz_q;
   logic             gnt0_q, gnt1_q, busy_q, done_q, done_id_q, err_q;
   logic [RW-1:0]    y_q;

   logic             win;
   logic [WIDTH-1:0] a_w, b_w;
   logic [2:0]       sel_w;
   logic [RW-1:0]    prod_d, exec_y;
   logic             exec_err;
   logic [WIDTH:0]   trial;
   logic             qbit;
   logic [WIDTH-1:0] rem_d, quo_d;
   logic             last_step;

   // Arbitration: a lone request wins; on a tie the requester not served last wins.
   always_comb begin
      win = ~last_q;
      if (bus.req0 && !bus.req1) win = 1'b0;
      else if (bus.req1 && !bus.req0) win = 1'b1;
      a_w   = win ? bus.a1   : bus.a0;
      b_w   = win ? bus.b1   : bus.b0;
      sel_w = win ? bus.sel1 : bus.sel0;
   end

   // One shift-add step, one restoring-division step, and the single-cycle ops.
   always_comb begin
      prod_d    = sh_q[0] ? prod_q + mcand_q : prod_q;
      trial     = {rem_q, sh_q[WIDTH-1]};
      qbit      = (trial >= {1'b0, b_q});
      rem_d     = qbit ? WIDTH'(trial - {1'b0, b_q}) : trial[WIDTH-1:0];
      quo_d     = WIDTH'({sh_q, qbit});
      last_step = (cnt_q == CW'(WIDTH - 1));
      exec_y    = '0;
      exec_err  = 1'b0;
      case (op_q)
         OP_ADD:  exec_y = RW'(a_q) + RW'(b_q);
         OP_SUB:  exec_y = RW'(a_q) - RW'(b_q);
         default: exec_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         last_q    <= 1'b1;
         cnt_q     <= '0;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         sh_q      <= '0;
         rem_q     <= '0;
         mcand_q   <= '0;
         prod_q    <= '0;
         divz_q    <= 1'b0;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= 1'b0;
         err_q     <= 1'b0;
         y_q       <= '0;
      end else begin
         gnt0_q <= 1'b0;
         gnt1_q <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.req0 || bus.req1) begin
                  last_q  <= win;
                  gnt0_q  <= ~win;
                  gnt1_q  <= win;
                  busy_q  <= 1'b1;
                  op_q    <= sel_w;
                  a_q     <= a_w;
                  b_q     <= b_w;
                  cnt_q   <= '0;
                  mcand_q <= RW'(a_w);
                  prod_q  <= '0;
                  rem_q   <= '0;
                  sh_q    <= (sel_w == OP_MUL) ? b_w : a_w;
                  divz_q  <= (b_w == '0);
                  state_q <= (sel_w == OP_MUL) ? MUL : (sel_w == OP_DIV) ? DIV : EXEC;
               end
            end
            EXEC: begin
               y_q       <= exec_y;
               err_q     <= exec_err;
               done_q    <= 1'b1;
               done_id_q <= last_q;
               busy_q    <= 1'b0;
               state_q   <= IDLE;
            end
            MUL: begin
               prod_q  <= prod_d;
               mcand_q <= mcand_q << 1;
               sh_q    <= sh_q >> 1;
               cnt_q   <= cnt_q + CW'(1);
               if (last_step) begin
                  y_q       <= prod_d;
                  err_q     <= 1'b0;
                  done_q    <= 1'b1;
                  done_id_q <= last_q;
                  busy_q    <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            DIV: begin
               rem_q <= rem_d;
               sh_q  <= quo_d;
               cnt_q <= cnt_q + CW'(1);
               if (last_step) begin
                  y_q       <= divz_q ? '1 : {rem_d, quo_d};
                  err_q     <= divz_q;
                  done_q    <= 1'b1;
                  done_id_q <= last_q;
                  busy_q    <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.gnt0    = gnt0_q;
   assign bus.gnt1    = gnt1_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.done_id = done_id_q;
   assign bus.y       = y_q;
   assign bus.err     = err_q;

`ifdef ALU_STATS_EN
   logic [15:0] ops0_q, ops1_q, errc_q;

   // Saturating counters advance once per done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ops0_q <= '0;
         ops1_q <= '0;
         errc_q <= '0;
      end else if (done_q) begin
         if (!done_id_q && ops0_q != 16'hFFFF) ops0_q <= ops0_q + 16'd1;
         if (done_id_q && ops1_q != 16'hFFFF)  ops1_q <= ops1_q + 16'd1;
         if (err_q && errc_q != 16'hFFFF)      errc_q <= errc_q + 16'd1;
      end
   end

   assign bus.ops_cnt0 = ops0_q;
   assign bus.ops_cnt1 = ops1_q;
   assign bus.err_cnt  = errc_q;
`endif
endmodule

// File: tb/tb_alu_rr_sched.sv
// Bench for alu_rr_sched: directed and random ops against an arithmetic reference model.
module tb_alu_rr_sched;
   localparam int unsigned W = 8;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   n_done0  = 0;
   int   n_done1  = 0;
   int   n_err    = 0;

   always #5 clk = ~clk;

   alu_rr_sched_if #(.WIDTH(W)) bus ();
   alu_rr_sched #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: result, error flag and cycles from grant to done, from plain arithmetic.
   function automatic void model(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                                 output logic [15:0] y, output logic e, output int lat);
      int ia = int'(a);
      int ib = int'(b);
      e = 1'b0;
      lat = 1;
      case (sel)
         3'd0: y = 16'(ia + ib);
         3'd1: y = 16'(ia - ib);
         3'd2: begin y = 16'(ia * ib); lat = 8; end
         3'd3: begin
            lat = 8;
            if (ib == 0) begin y = 16'hFFFF; e = 1'b1; end
            else y = 16'((ia % ib) * 256 + ia / ib);
         end
         default: begin y = 16'h0; e = 1'b1; end
      endcase
   endfunction

   task automatic drive(input bit id, input logic r, input logic [2:0] sel, input logic [7:0] a,
                        input logic [7:0] b);
      if (id) begin bus.req1 = r; bus.sel1 = sel; bus.a1 = a; bus.b1 = b; end
      else    begin bus.req0 = r; bus.sel0 = sel; bus.a0 = a; bus.b0 = b; end
   endtask

   task automatic count_done(input logic id, input logic e);
      if (id) n_done1++; else n_done0++;
      if (e) n_err++;
   endtask

   task automatic run_op(input bit id, input logic [2:0] sel, input logic [7:0] a,
                         input logic [7:0] b, input string tag);
      logic [15:0] ey;
      logic        ee;
      int          lat;
      int          n;
      model(sel, a, b, ey, ee, lat);
      @(negedge clk);
      drive(id, 1'b1, sel, a, b);
      @(negedge clk);
      n = 0;
      while (!(bus.gnt0 || bus.gnt1) && n < 20) begin @(negedge clk); n++; end
      chk({tag, ":gnt"}, 32'({bus.gnt1, bus.gnt0}), id ? 32'd2 : 32'd1);
      chk({tag, ":busy"}, 32'(bus.busy), 32'd1);
      drive(id, 1'b0, sel, a, b);
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.done && n < 40);
      chk({tag, ":lat"}, 32'(n), 32'(lat));
      chk({tag, ":y"}, 32'(bus.y), 32'(ey));
      chk({tag, ":err"}, 32'(bus.err), 32'(ee));
      chk({tag, ":id"}, 32'(bus.done_id), 32'(id));
      chk({tag, ":gntlo"}, 32'({bus.gnt1, bus.gnt0, bus.busy}), 32'd0);
      if (bus.done) count_done(bus.done_id, bus.err);
      @(negedge clk);
      chk({tag, ":pulse"}, 32'(bus.done), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      n_done0 = 0;
      n_done1 = 0;
      n_err   = 0;
   endtask

   initial begin
      logic [15:0] qy[$];
      logic        qid[$];
      logic [15:0] ey;
      logic        ee;
      int          lat;
      int          n;
      int          ng;
      int          nd;
      logic        exp_id;
      logic        pb;
      logic [7:0]  ra, rb;
      logic [2:0]  rs;
      logic [7:0]  ca[2];
      logic [7:0]  cb[2];

      bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0; bus.sel0 = '0;
      bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0; bus.sel1 = '0;
      do_reset();
      chk("rst:outs", 32'({bus.gnt0, bus.gnt1, bus.busy, bus.done, bus.done_id, bus.err}), 32'd0);
      chk("rst:y", 32'(bus.y), 32'd0);

      // Reset during MUL: abandoned, no done, then a clean rerun.
      @(negedge clk);
      drive(1'b0, 1'b1, 3'b010, 8'd200, 8'd150);
      @(negedge clk);
      n = 0;
      while (!bus.gnt0 && n < 20) begin @(negedge clk); n++; end
      chk("rmul:gnt", 32'(bus.gnt0), 32'd1);
      drive(1'b0, 1'b0, 3'b010, 8'd200, 8'd150);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rmul:outs", 32'({bus.gnt0, bus.gnt1, bus.busy, bus.done, bus.done_id, bus.err}), 32'd0);
      chk("rmul:y", 32'(bus.y), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      repeat (12) begin @(negedge clk); if (bus.done || bus.busy) n++; end
      chk("rmul:quiet", 32'(n), 32'd0);
      run_op(1'b0, 3'b010, 8'd200, 8'd150, "mul");

      run_op(1'b0, 3'b000, 8'd255, 8'd255, "add");
      run_op(1'b1, 3'b001, 8'd5, 8'd9, "sub");
      run_op(1'b0, 3'b011, 8'd200, 8'd7, "div");
      run_op(1'b0, 3'b011, 8'd77, 8'd0, "div0");
      run_op(1'b1, 3'b110, 8'd12, 8'd34, "ill");
      run_op(1'b1, 3'b010, 8'd255, 8'd255, "mulmax");
      run_op(1'b1, 3'b011, 8'd3, 8'd255, "divsm");

`ifdef ALU_STATS_EN
      chk("st:ops0", 32'(bus.ops_cnt0), 32'(n_done0));
      chk("st:ops1", 32'(bus.ops_cnt1), 32'(n_done1));
      chk("st:err", 32'(bus.err_cnt), 32'(n_err));
`endif

      // Contention after reset: both requesters hold ADD requests; grants must alternate from 0.
      do_reset();
      for (int i = 0; i < 2; i++) begin
         ca[i] = 8'($urandom);
         cb[i] = 8'($urandom);
         drive(i[0], 1'b1, 3'b000, ca[i], cb[i]);
      end
      exp_id = 1'b0;
      pb = 1'b0;
      ng = 0;
      nd = 0;
      for (int c = 0; c < 60 && nd < 6; c++) begin
         @(negedge clk);
         if (bus.done) begin
            chk("cont:qnz", 32'(qid.size() != 0), 32'd1);
            if (qid.size() != 0) begin
               chk("cont:id", 32'(bus.done_id), 32'(qid.pop_front()));
               chk("cont:y", 32'(bus.y), 32'(qy.pop_front()));
            end
            nd++;
         end
         if (bus.gnt0 || bus.gnt1) begin
            chk("cont:gnt", 32'({bus.gnt1, bus.gnt0}), exp_id ? 32'd2 : 32'd1);
            chk("cont:idlegnt", 32'(pb), 32'd0);
            model(3'b000, ca[exp_id], cb[exp_id], ey, ee, lat);
            qy.push_back(ey);
            qid.push_back(exp_id);
            ca[exp_id] = 8'($urandom);
            cb[exp_id] = 8'($urandom);
            drive(exp_id, 1'b1, 3'b000, ca[exp_id], cb[exp_id]);
            exp_id = ~exp_id;
            ng++;
         end
         pb = bus.busy;
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      chk("cont:ndone", 32'(nd), 32'd6);
      chk("cont:ngnt", 32'(ng), 32'd6);
      repeat (3) @(negedge clk);

      // Random ops across both requesters, including zero divisors and illegal opcodes.
      for (int i = 0; i < 20; i++) begin
         rs = 3'($urandom_range(0, 4));
         if (rs == 3'd4) rs = 3'($urandom_range(4, 7));
         ra = 8'($urandom);
         rb = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
         run_op(1'($urandom_range(0, 1)), rs, ra, rb, $sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
